note_playback_sequencer: RTL and testbench

- Sequences playback of the 16-entry note memory filled by the note-processing path.
- Issues read addresses and read enables to the note BRAM (1-cycle read latency) and captures each stored note code.
- Presents each note on a held output for a programmable number of ticks, then advances; supports single-pass and looped playback.
- Sits between the note BRAM read port and the audio/tone generator; starts only once the note buffer reports it is filled.

---
 rtl/note_playback_sequencer.sv | 164 ++++++++++++++++
 tb/tb_note_playback_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/note_playback_sequencer.sv
// Note playback sequencer: fetches note codes from a 1-cycle-latency BRAM and holds each for a programmable tick count.
// Build option NOTE_SEQ_REST_SKIP_EN: rests (code 0) are skipped in two cycles instead of played as silent notes.
module note_playback_sequencer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NOTE_W   = 8,
  parameter int unsigned DUR_W    = 16,
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic              mem_ready,
  input  logic [ADDR_W:0]   note_count,
  input  logic [DUR_W-1:0]  note_duration,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [NOTE_W-1:0] rd_data,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_on,
  output logic              note_strobe,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W   = ADDR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [DUR_W-1:0]   tick_q, tick_d;
  logic [NOTE_W-1:0]  note_d;
  logic               note_on_d, strobe_d, error_d;
  logic               start_ok, last_idx, presc_wrap, play_exit, advance, is_rest;

  // Next-state and next-register computation
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    dur_d      = dur_q;
    presc_d    = presc_q;
    tick_d     = tick_q;
    note_d     = note_out;
    note_on_d  = note_on;
    strobe_d   = 1'b0;
    error_d    = 1'b0;
    advance    = 1'b0;
    start_ok   = mem_ready && (note_count != '0) && (note_count <= CNT_W'(DEPTH));
    last_idx   = ({1'b0, idx_q} == (count_q - CNT_W'(1)));
    presc_wrap = (presc_q == PRESC_W'(TICK_DIV - 1));
    play_exit  = presc_wrap && ((tick_q + DUR_W'(1)) == dur_q);
    is_rest    = (rd_data == '0);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            count_d = note_count;
            dur_d   = (note_duration == '0) ? DUR_W'(1) : note_duration;
            idx_d   = '0;
            state_d = S_FETCH;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        presc_d = '0;
        tick_d  = '0;
`ifdef NOTE_SEQ_REST_SKIP_EN
        if (is_rest) begin
          advance = 1'b1;
        end else begin
          note_d    = rd_data;
          note_on_d = 1'b1;
          strobe_d  = 1'b1;
          state_d   = S_PLAY;
        end
`else
        note_d    = rd_data;
        note_on_d = !is_rest;
        strobe_d  = 1'b1;
        state_d   = S_PLAY;
`endif
      end
      S_PLAY: begin
        if (presc_wrap) begin
          presc_d = '0;
          tick_d  = tick_q + DUR_W'(1);
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
        advance = play_exit;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // End-of-note rules shared by PLAY exit and skipped rests
    if (advance) begin
      if (!last_idx) begin
        idx_d   = idx_q + ADDR_W'(1);
        state_d = S_FETCH;
      end else if (loop_en) begin
        idx_d   = '0;
        state_d = S_FETCH;
      end else begin
        note_d    = '0;
        note_on_d = 1'b0;
        state_d   = S_DONE;
      end
    end

    if ((state_q != S_IDLE) && stop) begin
      state_d   = S_IDLE;
      note_d    = '0;
      note_on_d = 1'b0;
      strobe_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      count_q     <= '0;
      dur_q       <= '0;
      presc_q     <= '0;
      tick_q      <= '0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      note_out    <= '0;
      note_on     <= 1'b0;
      note_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      dur_q       <= dur_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      rd_en       <= (state_d == S_FETCH);
      if (state_d == S_FETCH) rd_addr <= idx_d;
      note_out    <= note_d;
      note_on     <= note_on_d;
      note_strobe <= strobe_d;
      busy        <= (state_d != S_IDLE);
      done        <= (state_d == S_DONE);
      error       <= error_d;
    end
  end
endmodule

// File: tb/tb_note_playback_sequencer.sv
// Bench for note_playback_sequencer: directed and random playbacks scored against a queue-based timeline model.
module tb_note_playback_sequencer;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NOTE_W = 8;
  localparam int unsigned DUR_W  = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned TD     = 4;
  localparam int unsigned CNT_W  = ADDR_W + 1;
`ifdef NOTE_SEQ_REST_SKIP_EN
  localparam bit REST_SKIP = 1'b1;
`else
  localparam bit REST_SKIP = 1'b0;
`endif

  logic              clk = 1'b0, reset = 1'b0, start = 1'b0, stop = 1'b0;
  logic              loop_en = 1'b0, mem_ready = 1'b0;
  logic [CNT_W-1:0]  note_count = '0;
  logic [DUR_W-1:0]  note_duration = '0;
  logic              rd_en, note_on, note_strobe, busy, done, error;
  logic [ADDR_W-1:0] rd_addr;
  logic [NOTE_W-1:0] rd_data = '0;
  logic [NOTE_W-1:0] note_out;
  logic [NOTE_W-1:0] mem [DEPTH];
  int                cyc = 0;
  int                n_checks = 0, n_fail = 0;

  // kind: 0 note strobe, 1 done, 2 error; for fetches val is the address
  typedef struct {int kind; int at; int val;} ev_t;
  ev_t ev_q[$];
  ev_t addr_q[$];

  note_playback_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W), .TICK_DIV(TD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .mem_ready(mem_ready), .note_count(note_count), .note_duration(note_duration),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .note_out(note_out),
    .note_on(note_on), .note_strobe(note_strobe), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Timeline from the start edge c0: each entry costs 2+dur*TD cycles, a skipped rest 2
  task automatic model(input int c0, input int cnt, input int dur, input int passes,
                       input bit with_done, output int t_end);
    int t, d, p;
    t = c0;
    d = (dur == 0) ? 1 : dur;
    p = 2 + d * int'(TD);
    for (int k = 0; k < passes; k++) begin
      for (int i = 0; i < cnt; i++) begin
        addr_q.push_back('{kind: 0, at: t, val: i});
        if (mem[i] == '0 && REST_SKIP) begin
          t += 2;
        end else begin
          ev_q.push_back('{kind: 0, at: t + 2, val: int'(mem[i])});
          t += p;
        end
      end
    end
    if (with_done) ev_q.push_back('{kind: 1, at: t, val: 0});
    t_end = t;
  endtask

  initial begin : monitor
    ev_t e;
    int  kind;
    forever begin
      @(negedge clk);
      if (rd_en) begin
        if (addr_q.size() == 0) check("spurious rd_en", 1, 0);
        else begin
          e = addr_q.pop_front();
          check("fetch cycle", cyc, e.at);
          check("rd_addr", rd_addr, e.val);
        end
      end
      if (note_strobe || done || error) begin
        kind = note_strobe ? 0 : (done ? 1 : 2);
        if (ev_q.size() == 0) check("unexpected pulse kind+1", kind + 1, 0);
        else begin
          e = ev_q.pop_front();
          check("pulse kind", kind, e.kind);
          check("pulse cycle", cyc, e.at);
          if (e.kind == 0) begin
            check("note_out", note_out, e.val);
            check("note_on", note_on, e.val != 0);
          end else if (e.kind == 1) begin
            check("done note_out", note_out, 0);
            check("done busy", busy, 1);
          end else begin
            check("error busy", busy, 0);
          end
        end
      end
    end
  end

  task automatic finish_run(input int t_end, input string tag);
    while (cyc < t_end + 2) @(negedge clk);
    check({tag, " pulses left"}, ev_q.size(), 0);
    check({tag, " fetches left"}, addr_q.size(), 0);
    check({tag, " busy after"}, busy, 0);
    ev_q.delete();
    addr_q.delete();
  endtask

  task automatic issue_start(input int cnt, input int dur, input bit rdy, input bit lp, output int c0);
    @(negedge clk);
    note_count    = CNT_W'(cnt);
    note_duration = DUR_W'(dur);
    mem_ready     = rdy;
    loop_en       = lp;
    start         = 1'b1;
    c0            = cyc + 1;
  endtask

  task automatic run_directed(input int cnt, input int dur, input string tag);
    int c0, t_end;
    issue_start(cnt, dur, 1'b1, 1'b0, c0);
    model(c0, cnt, dur, 1, 1'b1, t_end);
    @(negedge clk);
    start = 1'b0;
    finish_run(t_end, tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rd_en"}, rd_en, 0);
    check({tag, " rd_addr"}, rd_addr, 0);
    check({tag, " note_out"}, note_out, 0);
    check({tag, " note_on"}, note_on, 0);
    check({tag, " note_strobe"}, note_strobe, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " error"}, error, 0);
  endtask

  initial begin : stim
    int c0, t_end, cnt, dur;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // Basic three-note single pass
    mem[0] = 8'h3C; mem[1] = 8'h3E; mem[2] = 8'h40;
    run_directed(3, 2, "basic");

    // Rejected starts
    issue_start(3, 2, 1'b0, 1'b0, c0);
    ev_q.push_back('{kind: 2, at: c0, val: 0});
    @(negedge clk); start = 1'b0;
    finish_run(c0, "not ready");
    issue_start(0, 2, 1'b1, 1'b0, c0);
    ev_q.push_back('{kind: 2, at: c0, val: 0});
    @(negedge clk); start = 1'b0;
    finish_run(c0, "count 0");
    issue_start(17, 2, 1'b1, 1'b0, c0);
    ev_q.push_back('{kind: 2, at: c0, val: 0});
    @(negedge clk); start = 1'b0;
    finish_run(c0, "count 17");

    // Looping, loop_en dropped during entry 1 of the second pass (period 6)
    mem[0] = 8'h11; mem[1] = 8'h22;
    issue_start(2, 1, 1'b1, 1'b1, c0);
    model(c0, 2, 1, 2, 1'b1, t_end);
    @(negedge clk); start = 1'b0;
    while (cyc < c0 + 21) @(negedge clk);
    loop_en = 1'b0;
    finish_run(t_end, "loop");

    // Stop mid-PLAY of entry 1 (period 14), then replay from entry 0
    mem[0] = 8'h50; mem[1] = 8'h51; mem[2] = 8'h52;
    issue_start(3, 3, 1'b1, 1'b0, c0);
    model(c0, 2, 3, 1, 1'b0, t_end);
    @(negedge clk); start = 1'b0;
    while (cyc < c0 + 20) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop busy", busy, 0);
    check("stop note_out", note_out, 0);
    check("stop note_on", note_on, 0);
    finish_run(c0 + 21, "stop");
    run_directed(3, 1, "replay");

    // Rest in the middle
    mem[0] = 8'h3C; mem[1] = 8'h00; mem[2] = 8'h40;
    run_directed(3, 1, "rest");

    // Reset mid-PLAY, then duration 0 plays one tick
    mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h63;
    issue_start(3, 3, 1'b1, 1'b0, c0);
    model(c0, 2, 3, 1, 1'b0, t_end);
    @(negedge clk); start = 1'b0;
    while (cyc < c0 + 20) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("async reset");
    @(negedge clk);
    reset = 1'b1;
    finish_run(c0 + 21, "reset");
    run_directed(2, 0, "dur0");

    // Random passes with noise on start/count/duration/mem_ready while busy
    for (int r = 0; r < 25; r++) begin
      cnt = int'($urandom_range(1, 16));
      dur = int'($urandom_range(0, 3));
      for (int i = 0; i < int'(DEPTH); i++)
        mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : NOTE_W'($urandom_range(1, 255));
      issue_start(cnt, dur, 1'b1, 1'b0, c0);
      model(c0, cnt, dur, 1, 1'b1, t_end);
      @(negedge clk);
      while (cyc < t_end) begin
        start         = ($urandom_range(0, 7) == 0);
        note_count    = CNT_W'($urandom);
        note_duration = DUR_W'($urandom);
        mem_ready     = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      start     = 1'b0;
      mem_ready = 1'b1;
      finish_run(t_end, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
